instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 118 +++++++++++
 tb/tb_instruction_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: takes 32-bit words over a valid/ready handshake and writes them
// big-endian, one byte per cycle, into byte-wide instruction memory. Optional macro
// INSTRUCTION_LOADER_CHECKSUM_EN adds an 8-bit running checksum output.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter logic [31:0] DEPTH_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        overflow
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam logic [31:0] END_ADDR = BASE_ADDR + DEPTH_BYTES;

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, FULL} state_t;

  state_t      state;
  logic [31:0] ptr;
  logic [31:0] ptr_next;
  logic [31:0] word_q;
  logic        last_q;
  logic [1:0]  byte_idx;

  assign ptr_next = ptr + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= BASE_ADDR;
      word_q     <= '0;
      last_q     <= 1'b0;
      byte_idx   <= '0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        WRITE: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          checksum <= checksum + mem_wdata;
`endif
          if (byte_idx == 2'd3) begin
            mem_we   <= 1'b0;
            ptr      <= ptr_next;
            byte_idx <= '0;
            if (last_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (ptr_next == END_ADDR) begin
              state <= FULL;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= ACCEPT;
              word_ready <= 1'b1;
            end
          end else begin
            // word_q shifts left so the next byte to emit is always at [23:16]
            mem_addr  <= mem_addr + 32'd1;
            mem_wdata <= word_q[23:16];
            word_q    <= {word_q[23:0], 8'h00};
            byte_idx  <= byte_idx + 2'd1;
          end
        end
        default: begin
          if (start) begin
            state      <= ACCEPT;
            ptr        <= BASE_ADDR;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
          end else if (state == FULL && word_valid) begin
            overflow <= 1'b1;
          end
          // word_ready is high throughout ACCEPT, so valid alone completes the handshake;
          // a simultaneous start restarts the session and the word lands at BASE_ADDR.
          if (state == ACCEPT && word_valid) begin
            state      <= WRITE;
            word_ready <= 1'b0;
            word_q     <= word_data;
            last_q     <= word_last;
            byte_idx   <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= start ? BASE_ADDR : ptr;
            mem_wdata  <= word_data[31:24];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed testbench for instruction_loader (default parameters: BASE_ADDR=0, DEPTH_BYTES=32).
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int passed = 0;
  int total  = 0;

  instruction_loader #(.BASE_ADDR(32'd0), .DEPTH_BYTES(32'd32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_byte(input string tag, input logic [31:0] addr, input logic [7:0] data);
    chk({tag, ".we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, ".addr"}, mem_addr, addr);
    chk({tag, ".data"}, {24'd0, mem_wdata}, {24'd0, data});
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
    tick(); tick();
    chk("rst.ready", {31'd0, word_ready}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.ovf", {31'd0, overflow}, 32'd0);
    chk("rst.we", {31'd0, mem_we}, 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.data", {24'd0, mem_wdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // valid in IDLE is ignored
    tick(); word_valid = 1'b1; tick(); tick();
    chk("idle.ready", {31'd0, word_ready}, 32'd0);
    chk("idle.ovf", {31'd0, overflow}, 32'd0);
    chk("idle.busy", {31'd0, busy}, 32'd0);
    word_valid = 1'b0;

    // single word
    start = 1'b1; tick(); start = 1'b0;
    chk("s1.ready", {31'd0, word_ready}, 32'd1);
    chk("s1.busy", {31'd0, busy}, 32'd1);
    word_valid = 1'b1; word_data = 32'h12345678; word_last = 1'b1;
    tick(); word_valid = 1'b0;
    chk_byte("s1.b0", 32'd0, 8'h12);
    chk("s1.notready", {31'd0, word_ready}, 32'd0);
    tick(); chk_byte("s1.b1", 32'd1, 8'h34);
    tick(); chk_byte("s1.b2", 32'd2, 8'h56);
    tick(); chk_byte("s1.b3", 32'd3, 8'h78);
    tick();
    chk("s1.we_off", {31'd0, mem_we}, 32'd0);
    chk("s1.done", {31'd0, done}, 32'd1);
    chk("s1.busy_off", {31'd0, busy}, 32'd0);
    chk("s1.addr_hold", mem_addr, 32'd3);
    chk("s1.data_hold", {24'd0, mem_wdata}, 32'h78);
    // valid in DONE is ignored
    word_valid = 1'b1; tick(); word_valid = 1'b0;
    chk("done.ovf", {31'd0, overflow}, 32'd0);
    chk("done.we", {31'd0, mem_we}, 32'd0);

    // fill with valid held high: transfers every 5 cycles
    start = 1'b1; tick(); start = 1'b0;
    word_valid = 1'b1; word_last = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w = 32'h11223344 + 32'h01010101 * k;
      word_data = w;
      chk("fill.ready", {31'd0, word_ready}, 32'd1);
      tick();
      chk_byte("fill.b0", 32'(4 * k), w[31:24]);
      for (int b = 1; b < 4; b++) begin
        chk("fill.bp", {31'd0, word_ready}, 32'd0);
        tick();
      end
      chk_byte("fill.b3", 32'(4 * k + 3), w[7:0]);
      tick();
    end
    chk("full.addr", mem_addr, 32'd31);
    chk("full.done", {31'd0, done}, 32'd1);
    chk("full.busy", {31'd0, busy}, 32'd0);
    chk("full.ready", {31'd0, word_ready}, 32'd0);
    chk("full.ovf0", {31'd0, overflow}, 32'd0);
    tick();
    chk("full.ovf1", {31'd0, overflow}, 32'd1);
    chk("full.we", {31'd0, mem_we}, 32'd0);
    word_valid = 1'b0; tick();
    chk("full.sticky", {31'd0, overflow}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart.ovf", {31'd0, overflow}, 32'd0);
    chk("restart.done", {31'd0, done}, 32'd0);
    chk("restart.busy", {31'd0, busy}, 32'd1);

    // start during WRITE is ignored
    word_valid = 1'b1; word_data = 32'hCAFEF00D; word_last = 1'b0;
    tick(); word_valid = 1'b0;
    chk_byte("sw.b0", 32'd0, 8'hCA);
    start = 1'b1; tick(); start = 1'b0;
    chk_byte("sw.b1", 32'd1, 8'hFE);
    tick(); chk_byte("sw.b2", 32'd2, 8'hF0);
    tick(); chk_byte("sw.b3", 32'd3, 8'h0D);
    tick();
    chk("sw.ready", {31'd0, word_ready}, 32'd1);
    chk("sw.done", {31'd0, done}, 32'd0);
    word_valid = 1'b1; word_data = 32'h01020304; word_last = 1'b1;
    tick(); word_valid = 1'b0;
    chk_byte("sw.next", 32'd4, 8'h01);
    tick(); tick(); tick(); tick();
    chk("sw.done2", {31'd0, done}, 32'd1);

    // reset mid-WRITE
    start = 1'b1; tick(); start = 1'b0;
    word_valid = 1'b1; word_data = 32'hAABBCCDD; word_last = 1'b1;
    tick(); word_valid = 1'b0;
    chk_byte("rw.b0", 32'd0, 8'hAA);
    tick(); chk_byte("rw.b1", 32'd1, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("rw.we", {31'd0, mem_we}, 32'd0);
    chk("rw.addr", mem_addr, 32'd0);
    chk("rw.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rw.we_held", {31'd0, mem_we}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("rw.idle_ready", {31'd0, word_ready}, 32'd0);
    chk("rw.idle_busy", {31'd0, busy}, 32'd0);
    chk("rw.idle_done", {31'd0, done}, 32'd0);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    start = 1'b1; tick(); start = 1'b0;
    chk("cs.clear", {24'd0, checksum}, 32'd0);
    word_valid = 1'b1; word_data = 32'h01020304; word_last = 1'b0;
    tick(); word_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("cs.mid", {24'd0, checksum}, 32'h0A);
    word_valid = 1'b1; word_data = 32'hFFFFFFFF; word_last = 1'b1;
    tick(); word_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("cs.done", {31'd0, done}, 32'd1);
    chk("cs.sum", {24'd0, checksum}, 32'h06);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
